// File: rtl/network_source_batch_pkg.sv
// Shared network, dispatch and source configuration packages for network_source_batch.
// Revision: 1.0
`default_nettype none

package network_config;
  localparam int NUM_INP      = 4;
  localparam int CHARGE_WIDTH = 8;
endpackage

package dispatch_config;
  localparam int NUM_OPC   = 4;
  localparam int PFX_WIDTH = 3;

  typedef enum logic [PFX_WIDTH-1:0] {
    OPC_RUN = 3'd0,
    OPC_SPK = 3'd1,
    OPC_SNC = 3'd2,
    OPC_CLR = 3'd3
  } opcode_t;
endpackage

package source_config;
  import network_config::*;
  import dispatch_config::*;
  export network_config::*;
  export dispatch_config::*;

  function automatic int cnt_width(input int spk_per_pkt);
    return (spk_per_pkt > 1) ? $clog2(spk_per_pkt) : 0;
  endfunction

  localparam int DEFAULT_SPK_PER_PKT = 2;
  localparam int IDX_WIDTH = $clog2(NUM_INP);
  localparam int SPK_WIDTH = IDX_WIDTH + CHARGE_WIDTH;
  localparam int CNT_WIDTH = cnt_width(DEFAULT_SPK_PER_PKT);

  localparam logic signed [CHARGE_WIDTH-1:0] CHARGE_MAX = $signed({1'b0, {(CHARGE_WIDTH-1){1'b1}}});
  localparam logic signed [CHARGE_WIDTH-1:0] CHARGE_MIN = $signed({1'b1, {(CHARGE_WIDTH-1){1'b0}}});

  // One extra bit of headroom: overflow shows up as the two top bits disagreeing.
  function automatic logic signed [CHARGE_WIDTH-1:0] sat_add(
    input logic signed [CHARGE_WIDTH-1:0] a,
    input logic signed [CHARGE_WIDTH-1:0] b
  );
    logic signed [CHARGE_WIDTH:0] sum;
    sum = $signed({a[CHARGE_WIDTH-1], a}) + $signed({b[CHARGE_WIDTH-1], b});
    if (sum[CHARGE_WIDTH] != sum[CHARGE_WIDTH-1])
      return sum[CHARGE_WIDTH] ? CHARGE_MIN : CHARGE_MAX;
    return sum[CHARGE_WIDTH-1:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/network_source_batch_slot.sv
// spike_slot_decode: splits an SPK payload into per-slot valid/index/charge fields.
// Revision: 1.0
`default_nettype none

module spike_slot_decode #(
  parameter int PAY_WIDTH   = 29,
  parameter int SPK_PER_PKT = 2,
  parameter int NUM_INP     = 4,
  parameter int CNT_WIDTH   = 1,
  localparam int CW         = network_config::CHARGE_WIDTH,
  localparam int IDX_WIDTH  = $clog2(NUM_INP),
  localparam int IDX_S      = (IDX_WIDTH > 0) ? IDX_WIDTH : 1,
  localparam int CNT_S      = (CNT_WIDTH > 0) ? CNT_WIDTH : 1
) (
  input  logic [PAY_WIDTH-1:0] payload,
  input  logic [CNT_S-1:0]     count_m1,
  output logic [SPK_PER_PKT-1:0] valid,
  output logic [IDX_S-1:0]     idx    [SPK_PER_PKT],
  output logic signed [CW-1:0] charge [SPK_PER_PKT],
  output logic                 bad
);
  localparam int SW       = IDX_WIDTH + CW;
  localparam int SLOT_TOP = PAY_WIDTH - 1 - CNT_WIDTH;

  logic [SPK_PER_PKT-1:0] bad_slot;
  logic unused_payload;

  // The count field and trailing pad bits are not needed here.
  assign unused_payload = ^payload;

  for (genvar s = 0; s < SPK_PER_PKT; s++) begin : g_slot
    logic [SW-1:0] raw;
    logic          in_count;
    logic          in_range;

    assign raw       = payload[SLOT_TOP - s*SW -: SW];
    assign charge[s] = raw[CW-1:0];

    if (IDX_WIDTH > 0) begin : g_idx
      assign idx[s] = raw[SW-1 -: IDX_S];
    end else begin : g_no_idx
      assign idx[s] = '0;
    end

    assign in_count    = (s <= int'(count_m1));
    assign in_range    = (int'(idx[s]) < NUM_INP);
    assign valid[s]    = in_count && in_range;
    assign bad_slot[s] = in_count && !in_range;
  end

  assign bad = |bad_slot;
endmodule

`default_nettype wire

// File: rtl/network_source_batch.sv
// network_source_batch: decodes RUN/SPK/SNC/CLR dispatch packets into network handshake and inputs.
// Revision: 1.0
`default_nettype none

module network_source_batch
  import dispatch_config::*;
#(
  parameter int PKT_WIDTH   = 32,
  parameter int SPK_PER_PKT = 2,
  parameter int ACCUMULATE  = 1,
  parameter int NUM_INP     = network_config::NUM_INP,
  localparam int CW         = network_config::CHARGE_WIDTH,
  localparam int RW         = PKT_WIDTH - PFX_WIDTH
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [PKT_WIDTH-1:0] src,
  input  logic                 net_ready,
  output logic                 net_sync,
  output logic                 net_arstn,
  output logic                 net_en,
  output logic signed [CW-1:0] net_inp [NUM_INP],
  output logic [RW-1:0]        run_remaining,
  output logic                 err_idx
);
  localparam int IW    = $clog2(NUM_INP);
  localparam int IDX_S = (IW > 0) ? IW : 1;
  localparam int CNTW  = source_config::cnt_width(SPK_PER_PKT);
  localparam int CNT_S = (CNTW > 0) ? CNTW : 1;
  localparam int SW    = IW + CW;

  if (PFX_WIDTH + CNTW + SPK_PER_PKT * SW > PKT_WIDTH) begin : g_cfg_check
    $error("network_source_batch: SPK fields do not fit in PKT_WIDTH");
  end

  logic [PFX_WIDTH-1:0]   opc;
  logic [RW-1:0]          payload;
  logic [CNT_S-1:0]       count_m1;
  logic                   acc;
  logic                   is_clr;
  logic                   is_spk;
  logic [SPK_PER_PKT-1:0] slot_valid;
  logic [IDX_S-1:0]       slot_idx    [SPK_PER_PKT];
  logic signed [CW-1:0]   slot_charge [SPK_PER_PKT];
  logic                   slot_bad;
  logic signed [CW-1:0]   nxt_inp     [NUM_INP];

  assign opc     = src[PKT_WIDTH-1 -: PFX_WIDTH];
  assign payload = src[RW-1:0];

  if (CNTW > 0) begin : g_cnt
    assign count_m1 = payload[RW-1 -: CNT_S];
  end else begin : g_no_cnt
    assign count_m1 = '0;
  end

  assign net_en    = (run_remaining != '0) && net_ready;
  assign src_ready = ((run_remaining == '0) && !net_sync) ||
                     ((run_remaining <= RW'(1)) && net_ready);
  assign acc       = src_valid && src_ready;
  assign is_clr    = acc && (opc == OPC_CLR);
  assign is_spk    = acc && (opc == OPC_SPK);

  spike_slot_decode #(
    .PAY_WIDTH  (RW),
    .SPK_PER_PKT(SPK_PER_PKT),
    .NUM_INP    (NUM_INP),
    .CNT_WIDTH  (CNTW)
  ) u_decode (
    .payload (payload),
    .count_m1(count_m1),
    .valid   (slot_valid),
    .idx     (slot_idx),
    .charge  (slot_charge),
    .bad     (slot_bad)
  );

  // A timestep consumed in the SPK cycle means the new spikes start from zero.
  always_comb begin
    for (int i = 0; i < NUM_INP; i++) begin
      nxt_inp[i] = net_inp[i];
      if (is_clr) begin
        nxt_inp[i] = '0;
      end else if (is_spk) begin
        nxt_inp[i] = net_en ? '0 : net_inp[i];
        for (int s = 0; s < SPK_PER_PKT; s++) begin
          if (slot_valid[s] && (int'(slot_idx[s]) == i)) begin
            if (ACCUMULATE != 0)
              nxt_inp[i] = source_config::sat_add(nxt_inp[i], slot_charge[s]);
            else
              nxt_inp[i] = slot_charge[s];
          end
        end
      end else if (net_en) begin
        nxt_inp[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      run_remaining <= '0;
      net_sync      <= 1'b0;
      net_arstn     <= 1'b0;
      err_idx       <= 1'b0;
      for (int i = 0; i < NUM_INP; i++) net_inp[i] <= '0;
    end else begin
      if (acc && (opc == OPC_RUN) && (payload != '0))
        run_remaining <= payload;
      else if (net_en)
        run_remaining <= run_remaining - RW'(1);

      if (acc && (opc == OPC_SNC))
        net_sync <= 1'b1;
      else if (net_ready)
        net_sync <= 1'b0;

      net_arstn <= !is_clr;

      if (is_clr)
        err_idx <= 1'b0;
      else if (is_spk && slot_bad)
        err_idx <= 1'b1;

      for (int i = 0; i < NUM_INP; i++) net_inp[i] <= nxt_inp[i];
    end
  end
endmodule

`default_nettype wire
